// File: rtl/pc_unit_if.sv
// Fetch/redirect bundle between the PC unit, instruction memory and the branch/exception logic.
// The master drives redirects and fetch acceptance; the slave (pc_unit) drives the fetch request.
interface pc_unit_if #(
  parameter int XLEN = 32
) ();
  logic            stall;
  logic            fetch_ready;
  logic            fetch_valid;
  logic [XLEN-1:0] pc_current;
  logic [XLEN-1:0] pc_plus4;
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic            trap;
  logic            mret;
  logic [XLEN-1:0] epc;
  logic            misalign_fault;

  modport master (
    output stall, fetch_ready, br_taken, br_target, trap, mret,
    input  fetch_valid, pc_current, pc_plus4, epc, misalign_fault
  );

  modport slave (
    input  stall, fetch_ready, br_taken, br_target, trap, mret,
    output fetch_valid, pc_current, pc_plus4, epc, misalign_fault
  );
endinterface

// File: rtl/pc_unit.sv
// RV32I program-counter unit: fetch PC with priority redirect (trap > mret > branch > sequential),
// fetch handshake, exception PC and misaligned-redirect fault.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              IALIGN       = 32
) (
  input logic      clk,
  input logic      rst_n,
  pc_unit_if.slave bus
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;

  // Low address bits that must be zero for a legal redirect target (1 bit for C-ext, 2 otherwise).
  localparam logic [XLEN-1:0] ALIGN_MASK = (IALIGN == 16) ? XLEN'(1) : XLEN'(3);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            fetch_valid_q;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] pc_plus4;
  logic            target_misaligned;
  logic            advance;

  assign pc_plus4          = pc_q + XLEN'(4);
  assign target_misaligned = (bus.br_target & ALIGN_MASK) != '0;
  assign advance           = fetch_valid_q && bus.fetch_ready && !bus.stall;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    fault_d = 1'b0;

    case (state_q)
      BOOT: state_d = RUN;

      RUN: begin
        if (bus.trap) begin
          pc_d  = TRAP_VECTOR;
          epc_d = pc_q;
        end else if (bus.mret) begin
          pc_d = epc_q;
        end else if (bus.br_taken) begin
          if (target_misaligned) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            pc_d = bus.br_target;
          end
        end else if (advance) begin
          pc_d = pc_plus4;
        end
      end

      FAULT: begin
        // Only a trap leaves FAULT; mret and branches are ignored here.
        if (bus.trap) begin
          pc_d    = TRAP_VECTOR;
          epc_d   = pc_q;
          state_d = RUN;
        end
      end

      default: state_d = BOOT;
    endcase
  end

  // NOTE: every register here has an async reset value; there is no memory array to leave unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      epc_q         <= '0;
      fetch_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the same pre-edge values.
      state_q       <= state_d;
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      fetch_valid_q <= (state_d == RUN);
      fault_q       <= fault_d;
    end
  end

  assign bus.fetch_valid    = fetch_valid_q;
  assign bus.pc_current     = pc_q;
  assign bus.pc_plus4       = pc_plus4;
  assign bus.epc            = epc_q;
  assign bus.misalign_fault = fault_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: IALIGN=32 and IALIGN=16 instances driven in lockstep, each checked against
// its own behavioural model through directed steps followed by a randomized phase.
module tb_pc_unit;

  localparam logic [31:0] RST_VEC  = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  typedef enum {M_BOOT, M_RUN, M_FAULT} mode_e;
  typedef struct {
    mode_e       mode;
    logic [31:0] pc;
    logic [31:0] epc;
    bit          fault;
  } model_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, fetch_ready, br_taken, trap, mret;
  logic [31:0] br_target;

  int n_cmp = 0;
  int n_err = 0;

  model_t m32, m16;

  pc_unit_if #(.XLEN(32)) if32 ();
  pc_unit_if #(.XLEN(32)) if16 ();

  assign if32.stall = stall;       assign if16.stall = stall;
  assign if32.fetch_ready = fetch_ready; assign if16.fetch_ready = fetch_ready;
  assign if32.br_taken = br_taken; assign if16.br_taken = br_taken;
  assign if32.br_target = br_target; assign if16.br_target = br_target;
  assign if32.trap = trap;         assign if16.trap = trap;
  assign if32.mret = mret;         assign if16.mret = mret;

  pc_unit #(.XLEN(32), .RESET_VECTOR(RST_VEC), .TRAP_VECTOR(TRAP_VEC), .IALIGN(32)) u32 (
    .clk(clk), .rst_n(rst_n), .bus(if32.slave)
  );
  pc_unit #(.XLEN(32), .RESET_VECTOR(RST_VEC), .TRAP_VECTOR(TRAP_VEC), .IALIGN(16)) u16 (
    .clk(clk), .rst_n(rst_n), .bus(if16.slave)
  );

  always #5 clk = ~clk;

  function automatic model_t model_reset();
    model_t r;
    r.mode = M_BOOT; r.pc = RST_VEC; r.epc = 32'h0; r.fault = 1'b0;
    return r;
  endfunction

  // One clock edge of the specified behaviour, given the instruction alignment in bytes.
  function automatic model_t model_step(input model_t m, input int unsigned align_bytes);
    model_t n = m;
    n.fault = 1'b0;
    case (m.mode)
      M_BOOT: n.mode = M_RUN;
      M_RUN: begin
        if (trap) begin
          n.pc = TRAP_VEC; n.epc = m.pc;
        end else if (mret) begin
          n.pc = m.epc;
        end else if (br_taken) begin
          if ((br_target % align_bytes) != 0) begin
            n.mode = M_FAULT; n.fault = 1'b1;
          end else begin
            n.pc = br_target;
          end
        end else if (fetch_ready && !stall) begin
          n.pc = m.pc + 32'd4;
        end
      end
      M_FAULT: if (trap) begin
        n.pc = TRAP_VEC; n.epc = m.pc; n.mode = M_RUN;
      end
      default: n = model_reset();
    endcase
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check($sformatf("%s.pc32", tag), if32.pc_current, m32.pc);
    check($sformatf("%s.epc32", tag), if32.epc, m32.epc);
    check($sformatf("%s.fv32", tag), 32'(if32.fetch_valid), 32'(m32.mode == M_RUN));
    check($sformatf("%s.mf32", tag), 32'(if32.misalign_fault), 32'(m32.fault));
    check($sformatf("%s.p4_32", tag), if32.pc_plus4, m32.pc + 32'd4);
    check($sformatf("%s.pc16", tag), if16.pc_current, m16.pc);
    check($sformatf("%s.epc16", tag), if16.epc, m16.epc);
    check($sformatf("%s.fv16", tag), 32'(if16.fetch_valid), 32'(m16.mode == M_RUN));
    check($sformatf("%s.mf16", tag), 32'(if16.misalign_fault), 32'(m16.fault));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    m32 = model_step(m32, 4);
    m16 = model_step(m16, 2);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic clear_redirects();
    br_taken = 1'b0; trap = 1'b0; mret = 1'b0; stall = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; fetch_ready = 1'b1;
    br_taken = 1'b0; br_target = 32'h0; trap = 1'b0; mret = 1'b0;
    m32 = model_reset(); m16 = model_reset();

    // Reset, one-cycle BOOT bubble, then sequential fetch.
    @(negedge clk);
    compare_all("reset");
    rst_n = 1'b1;
    #1 compare_all("boot");
    step("run0");
    check("seq.pc0", if32.pc_current, 32'h0);
    step("seq4");
    step("seq8");
    check("seq.pc8", if32.pc_current, 32'h8);

    // Stall holds; a branch overrides the stall.
    stall = 1'b1;
    repeat (3) step("stall");
    check("stall.pc", if32.pc_current, 32'h8);
    br_taken = 1'b1; br_target = 32'h40;
    step("br_stall");
    check("br_stall.pc", if32.pc_current, 32'h40);
    clear_redirects();

    // Simultaneous trap/mret/branch: trap wins. Then mret returns.
    trap = 1'b1; mret = 1'b1; br_taken = 1'b1; br_target = 32'h80;
    step("trap_prio");
    check("trap_prio.pc", if32.pc_current, 32'h100);
    check("trap_prio.epc", if32.epc, 32'h40);
    clear_redirects();
    mret = 1'b1;
    step("mret");
    check("mret.pc", if32.pc_current, 32'h40);
    clear_redirects();

    // Misaligned target: IALIGN=32 faults, IALIGN=16 accepts.
    br_taken = 1'b1; br_target = 32'h22;
    step("misalign");
    check("misalign.mf32", 32'(if32.misalign_fault), 32'h1);
    check("misalign.pc16", if16.pc_current, 32'h22);
    clear_redirects();
    mret = 1'b1; br_taken = 1'b1; br_target = 32'h200;
    step("fault_ignore");
    clear_redirects();
    trap = 1'b1;
    step("fault_trap");
    check("fault_trap.epc32", if32.epc, 32'h40);
    clear_redirects();

    // Wrap at the top of the address space.
    br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
    step("br_top");
    clear_redirects();
    step("wrap");
    check("wrap.pc", if32.pc_current, 32'h0);

    // Asynchronous reset between edges.
    trap = 1'b1;
    step("trap2");
    clear_redirects();
    fetch_ready = 1'b0;
    #2 rst_n = 1'b0;
    m32 = model_reset(); m16 = model_reset();
    #1 compare_all("mid_rst");
    @(negedge clk);
    compare_all("rst_hold");
    rst_n = 1'b1;
    fetch_ready = 1'b1;
    step("boot2");
    step("adv");
    mret = 1'b1;
    step("mret_noprior");
    check("mret_noprior.pc", if32.pc_current, 32'h0);
    clear_redirects();

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      stall       = ($urandom_range(3) == 0);
      fetch_ready = ($urandom_range(3) != 0);
      trap        = ($urandom_range(15) == 0);
      mret        = ($urandom_range(15) == 0);
      br_taken    = ($urandom_range(7) == 0);
      case ($urandom_range(3))
        0:       br_target = $urandom;
        1:       br_target = 32'hFFFF_FFFC;
        default: br_target = $urandom & 32'hFFFF_FFFC;
      endcase
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
